// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display scheduler.
//   - state_e      : scheduler FSM states
//   - SEG_*        : active-low segment codes, bit order abcdefg
//   - AN_*         : active-low anode patterns, one per digit position
//   - digit_to_seg : BCD nibble to segment code
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHOW    = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_THOU = 4'b0111;
    localparam logic [3:0] AN_HUND = 4'b1011;
    localparam logic [3:0] AN_TENS = 4'b1101;
    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Nibbles above 9 cannot come out of the converter; map them to "0".
    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_0;
        endcase
    endfunction

endpackage

// File: rtl/seq_bin2bcd.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per cycle.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load value and begin (ignored while a conversion runs)
//   value      : binary input, VAL_W bits
//   done       : combinational pulse on the final iteration cycle
//   digits     : {thousands, hundreds, tens, ones}; valid while done=1
module seq_bin2bcd #(
    parameter int VAL_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [VAL_W-1:0] value,
    output logic             done,
    output logic [15:0]      digits
);
    localparam int IT_W = $clog2(VAL_W);

    logic [VAL_W-1:0] sh_q, sh_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [IT_W-1:0]  it_q, it_d;
    logic             run_q, run_d;
    logic [15:0]      adj;

    always_comb begin
        adj = bcd_q;
        for (int n = 0; n < 4; n++) begin
            if (bcd_q[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
        end

        sh_d  = sh_q;
        bcd_d = bcd_q;
        it_d  = it_q;
        run_d = run_q;
        done  = 1'b0;

        if (run_q) begin
            bcd_d = {adj[14:0], sh_q[VAL_W-1]};
            sh_d  = sh_q << 1;
            it_d  = it_q - IT_W'(1);
            // Final iteration: the result is handed out in the same cycle
            // so the caller can commit without an extra flop stage.
            if (it_q == '0) begin
                done  = 1'b1;
                run_d = 1'b0;
            end
        end else if (start) begin
            sh_d  = value;
            bcd_d = '0;
            it_d  = IT_W'(VAL_W - 1);
            run_d = 1'b1;
        end
    end

    assign digits = bcd_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q  <= '0;
            bcd_q <= '0;
            it_q  <= '0;
            run_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            bcd_q <= bcd_d;
            it_q  <= it_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/seven_seg_display_scheduler.sv
// Shares one 4-digit seven-segment display among NUM_REQ requesters.
// Round-robin arbiter -> sequential BCD conversion -> fixed dwell, while a
// free-running refresh counter scans the anodes continuously.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   req         : per-requester level request
//   req_num     : packed values, requester i at [i*VAL_W +: VAL_W]
//   grant       : one-hot pulse when a value is captured
//   active_src  : index of the requester currently displayed
//   busy        : high while converting
//   bcd_valid   : pulse when new digits are committed
//   Anode       : active-low digit enables
//   LED_out     : active-low segments, abcdefg
module seven_seg_display_scheduler
    import seven_seg_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int VAL_W        = 13,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int REFRESH_BITS = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*VAL_W-1:0]   req_num,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] active_src,
    output logic                       busy,
    output logic                       bcd_valid,
    output logic [3:0]                 Anode,
    output logic [6:0]                 LED_out
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int DW_W  = $clog2(DWELL_CYCLES + 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]        win_q, win_d;
    logic [IDX_W-1:0]        act_q, act_d;
    logic                    bv_q, bv_d;
    logic [15:0]             disp_q, disp_d;
    logic                    dv_q, dv_d;
    logic [DW_W-1:0]         dwell_q, dwell_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;

    logic             found;
    logic [IDX_W-1:0] pick;
    int               idx;
    logic             start_cvt;
    logic             cvt_done;
    logic [15:0]      cvt_digits;

    // First asserted requester at or after the rr pointer, wrapping upward.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    assign start_cvt = (state_q == IDLE) && found;

    seq_bin2bcd #(.VAL_W(VAL_W)) u_bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_cvt),
        .value  (req_num[int'(pick)*VAL_W +: VAL_W]),
        .done   (cvt_done),
        .digits (cvt_digits)
    );

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = '0;
        win_d     = win_q;
        act_d     = act_q;
        bv_d      = 1'b0;
        disp_d    = disp_q;
        dv_d      = dv_q;
        dwell_d   = dwell_q;
        refresh_d = refresh_q + REFRESH_BITS'(1);

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d[pick] = 1'b1;
                    win_d         = pick;
                    rr_d          = IDX_W'((int'(pick) + 1) % NUM_REQ);
                    state_d       = CONVERT;
                end
            end
            CONVERT: begin
                if (cvt_done) begin
                    disp_d  = cvt_digits;
                    bv_d    = 1'b1;
                    act_d   = win_q;
                    dv_d    = 1'b1;
                    dwell_d = DW_W'(DWELL_CYCLES);
                    state_d = SHOW;
                end
            end
            SHOW: begin
                // Requests are not looked at here; only the countdown runs.
                if (dwell_q == '0) state_d = IDLE;
                else               dwell_d = dwell_q - DW_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            grant_q   <= '0;
            win_q     <= '0;
            act_q     <= '0;
            bv_q      <= 1'b0;
            disp_q    <= '0;
            dv_q      <= 1'b0;
            dwell_q   <= '0;
            refresh_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            win_q     <= win_d;
            act_q     <= act_d;
            bv_q      <= bv_d;
            disp_q    <= disp_d;
            dv_q      <= dv_d;
            dwell_q   <= dwell_d;
            refresh_q <= refresh_d;
        end
    end

    // Scan mux: purely combinational from registered state, blank until
    // the first value has been committed.
    logic [3:0] nib;
    always_comb begin
        Anode   = AN_OFF;
        LED_out = SEG_BLANK;
        nib     = '0;
        if (dv_q) begin
            case (refresh_q[REFRESH_BITS-1 -: 2])
                2'b00:   begin Anode = AN_THOU; nib = disp_q[15:12]; end
                2'b01:   begin Anode = AN_HUND; nib = disp_q[11:8];  end
                2'b10:   begin Anode = AN_TENS; nib = disp_q[7:4];   end
                default: begin Anode = AN_ONES; nib = disp_q[3:0];   end
            endcase
            LED_out = digit_to_seg(nib);
        end
    end

    assign grant      = grant_q;
    assign active_src = act_q;
    assign busy       = (state_q == CONVERT);
    assign bcd_valid  = bv_q;

endmodule

// File: tb/tb_seven_seg_display_scheduler.sv
module tb_seven_seg_display_scheduler;
    localparam int NR = 4;
    localparam int VW = 13;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [NR*VW-1:0] req_num = '0;
    logic [NR-1:0]   grant;
    logic [1:0]      active_src;
    logic            busy;
    logic            bcd_valid;
    logic [3:0]      Anode;
    logic [6:0]      LED_out;

    seven_seg_display_scheduler #(
        .NUM_REQ(NR), .VAL_W(VW), .DWELL_CYCLES(8), .REFRESH_BITS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_num(req_num),
        .grant(grant), .active_src(active_src), .busy(busy),
        .bcd_valid(bcd_valid), .Anode(Anode), .LED_out(LED_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int bv_n  = 0;
    logic [3:0] gl_v[$];
    int         gl_t[$];
    logic [6:0] seg_tab[10];

    // Grant / commit log, sampled just after each active edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (grant != 0) begin
            gl_v.push_back(grant);
            gl_t.push_back(cyc);
        end
        if (bcd_valid) bv_n++;
    end

    typedef struct packed {
        logic [3:0]  req;
        logic [51:0] nums;
        logic [3:0]  g;
        logic [1:0]  src;
        logic [13:0] shown;
    } vec_t;

    function automatic logic [51:0] pack4(input int a, input int b, input int c, input int d);
        return {d[12:0], c[12:0], b[12:0], a[12:0]};
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input logic [3:0] an);
        int d;
        case (an)
            4'b0111: d = v / 1000;
            4'b1011: d = (v / 100) % 10;
            4'b1101: d = (v / 10) % 10;
            default: d = v % 10;
        endcase
        return seg_tab[d];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        do begin step(); n++; end while (grant == 0 && n < 60);
    endtask

    task automatic wait_bv(output int n);
        n = 0;
        do begin step(); n++; end while (!bcd_valid && n < 60);
    endtask

    task automatic chk_now(input string nm, input int v, inout logic [3:0] seen);
        int p;
        p = -1;
        case (Anode)
            4'b0111: p = 0;
            4'b1011: p = 1;
            4'b1101: p = 2;
            4'b1110: p = 3;
            default: p = -1;
        endcase
        if (p < 0) begin
            total++;
            bad++;
            $display("FAIL %s anode: got %b, not a single-digit enable", nm, Anode);
        end else begin
            seen[p] = 1'b1;
            chk({nm, " seg"}, LED_out, exp_seg(v, Anode));
        end
    endtask

    task automatic check_disp(input string nm, input int v);
        logic [3:0] seen;
        seen = '0;
        for (int c = 0; c < 16; c++) begin
            chk_now(nm, v, seen);
            step();
        end
        chk({nm, " all digits scanned"}, seen, 4'hf);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        step(2);
        rst_n = 1'b1;
    endtask

    vec_t tv[6];

    initial begin
        int n;
        int k;
        int gl0;
        int bv0;
        logic [3:0] seen;
        int rot_v[4];

        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111;
        seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b0000110;
        seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0000100;

        // rr pointer walks 0 ->1 ->3 ->0 ->2 ->3 ->1 through these.
        tv[0] = '{req:4'b0001, nums:pack4(1234, 111, 222, 333), g:4'b0001, src:2'd0, shown:14'd1234};
        tv[1] = '{req:4'b0100, nums:pack4(1, 2, 8191, 3),       g:4'b0100, src:2'd2, shown:14'd8191};
        tv[2] = '{req:4'b1000, nums:pack4(11, 22, 33, 0),       g:4'b1000, src:2'd3, shown:14'd0};
        tv[3] = '{req:4'b0010, nums:pack4(9, 5, 9, 9),          g:4'b0010, src:2'd1, shown:14'd5};
        tv[4] = '{req:4'b0110, nums:pack4(4, 4, 999, 4),        g:4'b0100, src:2'd2, shown:14'd999};
        tv[5] = '{req:4'b0011, nums:pack4(4096, 77, 8, 8),      g:4'b0001, src:2'd0, shown:14'd4096};

        // Reset state, then idle with no requests: display stays blank.
        step(3);
        chk("reset grant", grant, 0);
        chk("reset busy", busy, 0);
        chk("reset bcd_valid", bcd_valid, 0);
        chk("reset active_src", active_src, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            chk("idle blank", {Anode, LED_out, grant, busy, bcd_valid}, {4'hf, 7'h7f, 4'h0, 1'b0, 1'b0});
            step();
        end

        // Table: one request pattern per entry, req dropped right after grant.
        for (int i = 0; i < 6; i++) begin
            req     = tv[i].req;
            req_num = tv[i].nums;
            wait_grant(n);
            chk("vec grant latency", n, 1);
            chk("vec grant", grant, tv[i].g);
            chk("vec busy", busy, 1);
            req = '0;
            wait_bv(n);
            chk("vec bcd latency", n, 13);
            chk("vec active_src", active_src, tv[i].src);
            check_disp("vec digits", int'(tv[i].shown));
        end

        // All requesters held: grants rotate, 23 cycles apart.
        do_reset();
        gl_v.delete();
        gl_t.delete();
        rot_v[0] = 8191; rot_v[1] = 0; rot_v[2] = 5; rot_v[3] = 999;
        req_num = pack4(8191, 0, 5, 999);
        req = 4'hf;
        for (int i = 0; i < 5; i++) begin
            wait_bv(n);
            chk("rot bcd_valid", bcd_valid, 1);
            chk("rot active_src", active_src, i % 4);
            check_disp("rot digits", rot_v[i % 4]);
        end
        req = '0;
        step(40);
        if (gl_v.size() < 5) begin
            chk("rot grant count", gl_v.size(), 5);
        end else begin
            for (int i = 0; i < 5; i++) begin
                chk("rot grant order", gl_v[i], 32'(1 << (i % 4)));
                if (i > 0) chk("rot grant spacing", gl_t[i] - gl_t[i-1], 23);
            end
        end

        // New request raised during a conversion: old digits held until commit.
        do_reset();
        req_num = pack4(1234, 5678, 0, 0);
        req = 4'b0001;
        wait_grant(n);
        chk("hold grant0", grant, 4'b0001);
        req = 4'b0010;
        wait_bv(n);
        chk("hold first bcd", n, 13);
        wait_grant(n);
        chk("hold second grant delay", n, 10);
        chk("hold second grant", grant, 4'b0010);
        req = '0;
        k = 0;
        seen = '0;
        while (!bcd_valid && k < 30) begin
            chk_now("hold old digits", 1234, seen);
            chk("hold busy", busy, 1);
            step();
            k++;
        end
        chk("hold conversion length", k, 13);
        chk("hold active_src", active_src, 1);
        check_disp("hold new digits", 5678);

        // Reset at iteration 6 of a conversion.
        step(10);
        req_num = pack4(0, 0, 777, 0);
        req = 4'b0100;
        wait_grant(n);
        chk("abort grant", grant, 4'b0100);
        req = '0;
        step(6);
        rst_n = 1'b0;
        step();
        chk("abort blank", {Anode, LED_out}, {4'hf, 7'h7f});
        chk("abort busy", busy, 0);
        rst_n = 1'b1;
        bv0 = bv_n;
        gl0 = gl_v.size();
        step(40);
        chk("abort no bcd_valid", bv_n - bv0, 0);
        chk("abort no grant", gl_v.size() - gl0, 0);
        chk("abort still blank", {Anode, LED_out}, {4'hf, 7'h7f});
        req_num = pack4(321, 1, 2, 3);
        req = 4'hf;
        wait_grant(n);
        chk("abort rr back to 0", grant, 4'b0001);
        req = '0;
        wait_bv(n);
        check_disp("abort redo digits", 321);

        // Pulse on req[2] during SHOW is never served.
        step(10);
        req_num = pack4(42, 0, 99, 0);
        req = 4'b0001;
        wait_grant(n);
        req = '0;
        wait_bv(n);
        step(2);
        req = 4'b0100;
        step();
        req = '0;
        gl0 = gl_v.size();
        step(40);
        chk("show pulse no grant", gl_v.size() - gl0, 0);
        chk("show pulse idle", busy, 0);
        check_disp("show pulse digits", 42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
